pipe_hazard_ctrl: RTL and testbench
===================================

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-003 SHALL have port id_valid, input, 1 bit: the decode stage holds a valid instruction.
REQ-004 SHALL have port id_opcode, input, 2 bits: decode opcode (00 load-imm, 01 sll, 11 jump, 10 illegal).
REQ-005 SHALL have ports id_rs1, id_rs2 and id_rd, input, 4 bits each: decode source and destination register indices.
REQ-006 SHALL have ports wb_valid (input, 1 bit) and wb_rd (input, 4 bits): a register write is retiring this cycle.
REQ-007 SHALL have port if_stall, output, 1 bit: hold PC and the IF/ID register.
REQ-008 SHALL have port id_bubble, output, 1 bit: insert a NOP into ID/EX.
REQ-009 SHALL have port flush, output, 1 bit: squash the IF/ID contents.
REQ-010 SHALL have port illegal_op, output, 1 bit: sticky flag set by an illegal opcode.
REQ-011 SHALL have port stall_count, output, 16 bits: number of hazard-stall cycles.

Function
REQ-012 SHALL keep a 2-bit pending-write counter per register r1..r15; r0 is never pending.
REQ-013 An issue SHALL occur when id_valid=1, no hazard is present, and the state is not FLUSH.
REQ-014 On an issue of opcode 00 or 01 with id_rd!=0, the block SHALL increment cnt[id_rd].
REQ-015 On wb_valid with wb_rd!=0, the block SHALL decrement cnt[wb_rd]; if an increment and a decrement hit the same register in the same cycle, the counter SHALL stay unchanged.
REQ-016 Opcode 01 reads rs1 and rs2; opcodes 00 and 11 read no registers.
REQ-017 A RAW hazard SHALL exist when a read register r!=0 has cnt[r]!=0, except when cnt[r]==1 and wb_valid=1 with wb_rd==r in the same cycle (write-through bypass).
REQ-018 A WAW-limit hazard SHALL exist when opcode 00 or 01 targets rd with cnt[rd]==3.
REQ-019 On any hazard with id_valid=1, if_stall=1 and id_bubble=1 SHALL assert combinationally in the same cycle.
REQ-020 The FSM SHALL have states RUN, STALL and FLUSH; the reset state is RUN.
REQ-021 RUN->STALL on a hazard; STALL->RUN in the first cycle with no hazard (the instruction issues that cycle); STALL holds otherwise.
REQ-022 An issue of opcode 11 SHALL cause a transition to FLUSH on the next edge; FLUSH SHALL last exactly 1 cycle, then return to RUN.
REQ-023 In FLUSH, flush=1 and id_bubble=1; the ID instruction SHALL be discarded with no counter update and no hazard evaluation, and if_stall=0.
REQ-024 With id_valid=1 and opcode 10 in RUN or STALL, the block SHALL apply id_bubble=1 and no counter update, and set illegal_op on the next edge; illegal_op SHALL clear only on reset.
REQ-025 id_valid=0 SHALL produce no hazard and no issue; retirement still updates the counters.
REQ-026 Decrementing a counter that is already zero SHALL leave it at 0 (no wrap).

Reset
REQ-027 While rst=1, the block SHALL immediately force state=RUN, all cnt=0, illegal_op=0 and stall_count=0.
REQ-028 While rst=1, the outputs if_stall, id_bubble and flush SHALL be 0, even if asserted in the middle of a stall or flush.

Configuration
REQ-029 With macro PIPE_HAZARD_STALL_CNT_EN defined, stall_count SHALL increment on every cycle with if_stall=1 and saturate at 16'hFFFF.
REQ-030 With PIPE_HAZARD_STALL_CNT_EN undefined, stall_count SHALL be tied to 16'h0000 and no counter register SHALL be present.

Verification
REQ-031 Issue load-imm rd=3, then sll rs1=3 the next cycle with no writeback -> if_stall=1 and id_bubble=1; wb_valid with wb_rd=3 -> the stall drops in that same cycle and the sll issues.
REQ-032 Issue 3 load-imm to rd=5 with no retire, then a 4th load-imm rd=5 -> stall until one wb_rd=5 occurs; cnt[5] reaches 3 and never wraps.
REQ-033 Issue a jump -> flush=1 for exactly 1 cycle on the next cycle; the squashed instruction causes no counter change and no stall.
REQ-034 Opcode 10 with id_valid=1 -> id_bubble=1 and illegal_op=1 from the next cycle, remaining 1 until rst.
REQ-035 With the macro defined, hold a hazard for 4 cycles -> stall_count=4; assert rst mid-stall -> if_stall=0 immediately and stall_count=0.
REQ-036 Issue an sll targeting rd=0, then an sll reading rs1=0 -> no stall, and cnt stays 0.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: scoreboard-based RAW/WAW-limit stalls, jump flush, illegal-opcode trap.
// Optional stall-cycle counter is built only when PIPE_HAZARD_STALL_CNT_EN is defined.
module pipe_hazard_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid,
    input  logic [1:0]  id_opcode,
    input  logic [3:0]  id_rs1,
    input  logic [3:0]  id_rs2,
    input  logic [3:0]  id_rd,
    input  logic        wb_valid,
    input  logic [3:0]  wb_rd,
    output logic        if_stall,
    output logic        id_bubble,
    output logic        flush,
    output logic        illegal_op,
    output logic [15:0] stall_count,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2
    } state_e;

    localparam logic [1:0] OP_LI  = 2'b00;
    localparam logic [1:0] OP_SLL = 2'b01;
    localparam logic [1:0] OP_ILL = 2'b10;
    localparam logic [1:0] OP_JMP = 2'b11;

    state_e           state_q, state_d;
    logic [15:0][1:0] cnt_q, cnt_d;
    logic             illegal_q, illegal_d;

    logic is_write, is_read, is_illegal, in_flush;
    logic raw_rs1, raw_rs2, waw_rd;
    logic hazard, issue, bad_op;

    // ID is held by upstream whenever if_stall=1; both stall outputs are
    // combinational from the current ID contents and the scoreboard.
    always_comb begin
        is_write   = (id_opcode == OP_LI) || (id_opcode == OP_SLL);
        is_read    = (id_opcode == OP_SLL);
        is_illegal = (id_opcode == OP_ILL);
        in_flush   = (state_q == FLUSH);

        // A single outstanding write retiring this cycle is forwarded, so no stall.
        raw_rs1 = is_read && (id_rs1 != 4'd0) && (cnt_q[id_rs1] != 2'd0) &&
                  !((cnt_q[id_rs1] == 2'd1) && wb_valid && (wb_rd == id_rs1));
        raw_rs2 = is_read && (id_rs2 != 4'd0) && (cnt_q[id_rs2] != 2'd0) &&
                  !((cnt_q[id_rs2] == 2'd1) && wb_valid && (wb_rd == id_rs2));
        waw_rd  = is_write && (id_rd != 4'd0) && (cnt_q[id_rd] == 2'd3);

        hazard = id_valid && !in_flush && !is_illegal && (raw_rs1 || raw_rs2 || waw_rd);
        issue  = id_valid && !in_flush && !is_illegal && !hazard;
        bad_op = id_valid && !in_flush && is_illegal;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN, STALL: begin
                if (hazard)
                    state_d = STALL;
                else if (issue && (id_opcode == OP_JMP))
                    state_d = FLUSH;
                else
                    state_d = RUN;
            end
            FLUSH:   state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    // Same-cycle issue and retire on one register cancel out.
    always_comb begin
        cnt_d = cnt_q;
        cnt_d[0] = 2'd0;
        for (int r = 1; r < 16; r++) begin
            logic inc, dec;
            inc = issue && is_write && (id_rd == r[3:0]);
            dec = wb_valid && (wb_rd == r[3:0]);
            if (inc && !dec)
                cnt_d[r] = cnt_q[r] + 2'd1;
            else if (dec && !inc && (cnt_q[r] != 2'd0))
                cnt_d[r] = cnt_q[r] - 2'd1;
        end
    end

    always_comb begin
        illegal_d = illegal_q | bad_op;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= RUN;
            cnt_q     <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        if_stall   = !rst && hazard;
        id_bubble  = !rst && (hazard || in_flush || bad_op);
        flush      = !rst && in_flush;
        illegal_op = illegal_q;
        dbg_state  = state_q;
    end

`ifdef PIPE_HAZARD_STALL_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (if_stall && (stall_cnt_q != 16'hFFFF))
            stall_cnt_d = stall_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stall_cnt_q <= 16'h0000;
        else
            stall_cnt_q <= stall_cnt_d;
    end

    assign stall_count = stall_cnt_q;
`else
    assign stall_count = 16'h0000;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: inputs change on the falling edge, outputs are
// checked 1 ns later; expected values are hand-derived from the block's behaviour.
module tb_pipe_hazard_ctrl;

    localparam logic [1:0] LI  = 2'b00;
    localparam logic [1:0] SLL = 2'b01;
    localparam logic [1:0] ILL = 2'b10;
    localparam logic [1:0] JMP = 2'b11;

    localparam logic [1:0] S_RUN   = 2'd0;
    localparam logic [1:0] S_STALL = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;

    logic        clk;
    logic        rst;
    logic        id_valid;
    logic [1:0]  id_opcode;
    logic [3:0]  id_rs1, id_rs2, id_rd;
    logic        wb_valid;
    logic [3:0]  wb_rd;
    logic        if_stall, id_bubble, flush, illegal_op;
    logic [15:0] stall_count;
    logic [1:0]  dbg_state;

    int n_vec;
    int n_err;

    pipe_hazard_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .id_valid    (id_valid),
        .id_opcode   (id_opcode),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_rd       (id_rd),
        .wb_valid    (wb_valid),
        .wb_rd       (wb_rd),
        .if_stall    (if_stall),
        .id_bubble   (id_bubble),
        .flush       (flush),
        .illegal_op  (illegal_op),
        .stall_count (stall_count),
        .dbg_state   (dbg_state)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // driver: apply one ID/WB vector at the falling edge, settle 1 ns
    task automatic drive(input logic v, input logic [1:0] op, input logic [3:0] rs1,
                         input logic [3:0] rs2, input logic [3:0] rd,
                         input logic wv, input logic [3:0] wr);
        @(negedge clk);
        id_valid  = v;
        id_opcode = op;
        id_rs1    = rs1;
        id_rs2    = rs2;
        id_rd     = rd;
        wb_valid  = wv;
        wb_rd     = wr;
        #1;
    endtask

    task automatic idle_inputs();
        id_valid  = 1'b0;
        id_opcode = LI;
        id_rs1    = 4'd0;
        id_rs2    = 4'd0;
        id_rd     = 4'd0;
        wb_valid  = 1'b0;
        wb_rd     = 4'd0;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_ctl(input string tag, input logic st, input logic bub, input logic fl);
        chk({tag, ".if_stall"}, {15'd0, if_stall}, {15'd0, st});
        chk({tag, ".id_bubble"}, {15'd0, id_bubble}, {15'd0, bub});
        chk({tag, ".flush"}, {15'd0, flush}, {15'd0, fl});
    endtask

    initial begin
        logic [15:0] exp_sc;
        n_vec = 0;
        n_err = 0;

        // reset with an illegal op presented: nothing may assert
        rst = 1'b1;
        idle_inputs();
        id_valid  = 1'b1;
        id_opcode = ILL;
        @(posedge clk);
        #1;
        chk_ctl("reset", 1'b0, 1'b0, 1'b0);
        chk("reset.illegal_op", {15'd0, illegal_op}, 16'd0);
        chk("reset.stall_count", stall_count, 16'd0);
        chk("reset.state", {14'd0, dbg_state}, {14'd0, S_RUN});
        idle_inputs();
        @(negedge clk);
        rst = 1'b0;

        // RAW on r3 with write-through release
        drive(1, LI,  0, 0, 3, 0, 0);  chk_ctl("li_r3", 0, 0, 0);
        drive(1, SLL, 3, 0, 4, 0, 0);  chk_ctl("raw_r3", 1, 1, 0);
        chk("raw_r3.state", {14'd0, dbg_state}, {14'd0, S_RUN});
        drive(1, SLL, 3, 0, 4, 0, 0);  chk_ctl("raw_r3_hold", 1, 1, 0);
        chk("raw_r3_hold.state", {14'd0, dbg_state}, {14'd0, S_STALL});
        drive(1, SLL, 3, 0, 4, 1, 3);  chk_ctl("raw_r3_bypass", 0, 0, 0);
        drive(1, SLL, 4, 0, 6, 0, 0);  chk_ctl("raw_r4_after_issue", 1, 1, 0);
        chk("raw_r4.state", {14'd0, dbg_state}, {14'd0, S_RUN});
        drive(0, SLL, 4, 0, 6, 1, 4);  chk_ctl("novalid_retire", 0, 0, 0);
        chk("novalid.state", {14'd0, dbg_state}, {14'd0, S_STALL});
        drive(1, SLL, 3, 4, 0, 0, 0);  chk_ctl("r3_r4_clear", 0, 0, 0);
        chk("r3_r4_clear.state", {14'd0, dbg_state}, {14'd0, S_RUN});

        // r0 never pending; decrement of an empty counter stays at zero
        drive(1, SLL, 0, 0, 0, 0, 0);  chk_ctl("sll_rd0_rs0", 0, 0, 0);
        drive(1, SLL, 0, 0, 0, 0, 0);  chk_ctl("sll_rs0_again", 0, 0, 0);
        drive(0, LI,  0, 0, 0, 1, 7);
        drive(1, SLL, 7, 7, 0, 0, 0);  chk_ctl("no_wrap_r7", 0, 0, 0);

        // WAW limit on r5
        drive(1, LI, 0, 0, 5, 0, 0);   chk_ctl("li5_1", 0, 0, 0);
        drive(1, LI, 0, 0, 5, 0, 0);   chk_ctl("li5_2", 0, 0, 0);
        drive(1, LI, 0, 0, 5, 0, 0);   chk_ctl("li5_3", 0, 0, 0);
        drive(1, LI, 0, 0, 5, 0, 0);   chk_ctl("li5_4_waw", 1, 1, 0);
        drive(1, LI, 0, 0, 5, 0, 0);   chk_ctl("li5_4_hold", 1, 1, 0);
        drive(1, LI, 0, 0, 5, 1, 5);   chk_ctl("li5_4_wb_cycle", 1, 1, 0);
        drive(1, LI, 0, 0, 5, 0, 0);   chk_ctl("li5_4_issue", 0, 0, 0);
        chk("li5_4_issue.state", {14'd0, dbg_state}, {14'd0, S_STALL});
        drive(1, LI, 0, 0, 5, 0, 0);   chk_ctl("li5_5_full", 1, 1, 0);
        // cnt5 3 -> 2, then simultaneous inc/dec keeps 2, then one more fills it
        drive(0, LI, 0, 0, 0, 1, 5);
        drive(1, LI, 0, 0, 5, 1, 5);   chk_ctl("li5_inc_dec", 0, 0, 0);
        drive(1, LI, 0, 0, 5, 0, 0);   chk_ctl("li5_to3", 0, 0, 0);
        drive(1, LI, 0, 0, 5, 0, 0);   chk_ctl("li5_full_again", 1, 1, 0);
        drive(0, LI, 0, 0, 0, 1, 5);
        drive(0, LI, 0, 0, 0, 1, 5);
        drive(0, LI, 0, 0, 0, 1, 5);
        drive(1, SLL, 5, 5, 0, 0, 0);  chk_ctl("r5_drained", 0, 0, 0);

        // jump flush: the squashed slot neither stalls nor updates counters
        drive(1, LI,  0, 0, 8, 0, 0);  chk_ctl("li_r8", 0, 0, 0);
        drive(1, JMP, 0, 0, 0, 0, 0);  chk_ctl("jmp", 0, 0, 0);
        drive(1, SLL, 8, 0, 9, 0, 0);  chk_ctl("flush_cycle", 0, 1, 1);
        chk("flush_cycle.state", {14'd0, dbg_state}, {14'd0, S_FLUSH});
        drive(1, SLL, 9, 0, 0, 0, 0);  chk_ctl("after_flush", 0, 0, 0);
        chk("after_flush.state", {14'd0, dbg_state}, {14'd0, S_RUN});

        // illegal opcode: bubble now, sticky flag from the next cycle
        drive(1, ILL, 0, 0, 0, 0, 0);  chk_ctl("illegal", 0, 1, 0);
        chk("illegal.flag_now", {15'd0, illegal_op}, 16'd0);
        drive(0, LI, 0, 0, 0, 0, 0);   chk_ctl("illegal_next", 0, 0, 0);
        chk("illegal.flag_next", {15'd0, illegal_op}, 16'd1);
        drive(1, LI, 0, 0, 10, 0, 0);
        chk("illegal.flag_sticky", {15'd0, illegal_op}, 16'd1);

        // reset pulse clears flag and counters (r8 was left pending)
        #2 rst = 1'b1;
        #1 chk("rst_pulse.illegal_op", {15'd0, illegal_op}, 16'd0);
        idle_inputs();
        @(negedge clk);
        rst = 1'b0;
        drive(1, SLL, 8, 0, 0, 0, 0);  chk_ctl("r8_cleared", 0, 0, 0);

        // hold a hazard for four edges, then reset mid-stall
        drive(1, LI, 0, 0, 11, 0, 0);
        for (int i = 0; i < 4; i++) begin
            drive(1, SLL, 11, 0, 0, 0, 0);
            chk_ctl("stall_hold", 1, 1, 0);
        end
        drive(1, SLL, 11, 0, 0, 0, 0);
`ifdef PIPE_HAZARD_STALL_CNT_EN
        exp_sc = 16'd4;
`else
        exp_sc = 16'd0;
`endif
        chk("stall_count_4", stall_count, exp_sc);
        #2 rst = 1'b1;
        #1;
        chk_ctl("rst_mid_stall", 0, 0, 0);
        chk("rst_mid_stall.stall_count", stall_count, 16'd0);
        chk("rst_mid_stall.state", {14'd0, dbg_state}, {14'd0, S_RUN});
        idle_inputs();
        @(negedge clk);
        rst = 1'b0;
        drive(1, SLL, 11, 0, 0, 0, 0); chk_ctl("r11_cleared", 0, 0, 0);

        // reset during the flush cycle
        drive(1, JMP, 0, 0, 0, 0, 0);
        drive(1, LI, 0, 0, 0, 0, 0);   chk_ctl("flush_pre_rst", 0, 1, 1);
        #2 rst = 1'b1;
        #1;
        chk_ctl("rst_mid_flush", 0, 0, 0);
        chk("rst_mid_flush.state", {14'd0, dbg_state}, {14'd0, S_RUN});
        idle_inputs();
        @(negedge clk);
        rst = 1'b0;
        drive(0, LI, 0, 0, 0, 0, 0);   chk_ctl("idle_after_rst", 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
